// File: rtl/decoder_n_seq_if.sv
// rtl/decoder_n_seq_if.sv - select handshake and decoded-output bundle for decoder_n_seq
//
// Purpose: groups the select valid/ready handshake together with the registered
//          decoder outputs so producer and decoder connect through one port.
// Signals:
//   sel        N     select code to decode (master -> slave)
//   sel_valid  1     sel is valid this cycle (master -> slave)
//   sel_ready  1     decoder accepts sel this cycle (slave -> master)
//   y          OUTS  registered one-hot output, port polarity (slave -> master)
//   y_valid    1     y holds a decoded or scanned line (slave -> master)
//   scan_idx   N     active line index while scanning, else 0 (slave -> master)
//   wrap       1     one-cycle pulse when the scan wraps to line 0 (slave -> master)
interface decoder_n_seq_if #(
   parameter int N = 2
);
   localparam int OUTS = 2 ** N;

   logic [N-1:0]    sel;
   logic            sel_valid;
   logic            sel_ready;
   logic [OUTS-1:0] y;
   logic            y_valid;
   logic [N-1:0]    scan_idx;
   logic            wrap;

   modport master (
      output sel,
      output sel_valid,
      input  sel_ready,
      input  y,
      input  y_valid,
      input  scan_idx,
      input  wrap
   );

   modport slave (
      input  sel,
      input  sel_valid,
      output sel_ready,
      output y,
      output y_valid,
      output scan_idx,
      output wrap
   );
endinterface

// File: rtl/decoder_n_seq.sv
// rtl/decoder_n_seq.sv - registered N-to-2^N one-hot decoder with valid/ready select and auto-scan
//
// Purpose: decodes an accepted select code into a registered one-hot line, or in
//          scan mode walks a single active line across all outputs, each line
//          staying active for DWELL cycles. Outputs come straight from flops so
//          they are glitch-free; internally y is only ever zero or one-hot.
// Parameters:
//   N          select width, OUTS = 2**N output lines
//   DWELL      cycles each line stays active while scanning (>= 1)
//   STICKY     1: hold the last decoded line until en drops or mode changes
//              0: a decoded line is a one-cycle pulse unless another transfer follows
//   ACTIVE_LOW 1: y is inverted at the port (idle reads all ones)
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         block enable, 0 forces IDLE at the next edge
//   mode       0 = decode, 1 = scan
//   bus        decoder_n_seq_if slave: sel/sel_valid/sel_ready handshake and
//              y/y_valid/scan_idx/wrap outputs
module decoder_n_seq #(
   parameter int N          = 2,
   parameter int DWELL      = 4,
   parameter int STICKY     = 0,
   parameter int ACTIVE_LOW = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   decoder_n_seq_if.slave   bus
);
   localparam int OUTS = 2 ** N;
   localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_SCAN = 2'd2
   } state_t;

   state_t          state_q,    state_d;
   logic [OUTS-1:0] y_q,        y_d;
   logic            y_valid_q,  y_valid_d;
   logic [N-1:0]    scan_idx_q, scan_idx_d;
   logic            wrap_q,     wrap_d;
   logic [CW-1:0]   cnt_q,      cnt_d;

   logic            sel_ready;
   logic            xfer;
   logic            dwell_done;

   function automatic logic [OUTS-1:0] onehot(input logic [N-1:0] idx);
      logic [OUTS-1:0] o;
      o      = '0;
      o[idx] = 1'b1;
      return o;
   endfunction

   // Ready depends on the reset pin directly so nothing is accepted while reset
   // is held, even though the state register is already IDLE.
   assign sel_ready  = rst_n & en & ~mode & (state_q != ST_SCAN);
   assign xfer       = bus.sel_valid & sel_ready;
   assign dwell_done = (cnt_q == CW'(DWELL - 1));

   always_comb begin
      state_d    = state_q;
      y_d        = y_q;
      y_valid_d  = y_valid_q;
      scan_idx_d = scan_idx_q;
      wrap_d     = 1'b0;
      cnt_d      = cnt_q;

      if (!en) begin
         state_d    = ST_IDLE;
         y_d        = '0;
         y_valid_d  = 1'b0;
         scan_idx_d = '0;
         cnt_d      = '0;
      end else if (mode) begin
         if (state_q == ST_SCAN) begin
            if (dwell_done) begin
               cnt_d      = '0;
               // scan_idx is exactly N bits, so the increment wraps modulo OUTS
               scan_idx_d = scan_idx_q + 1'b1;
               wrap_d     = &scan_idx_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            y_d       = onehot(scan_idx_d);
            y_valid_d = 1'b1;
         end else begin
            // entering scan from IDLE or HOLD always restarts at line 0
            state_d    = ST_SCAN;
            y_d        = onehot('0);
            y_valid_d  = 1'b1;
            scan_idx_d = '0;
            cnt_d      = '0;
         end
      end else if (state_q == ST_SCAN) begin
         state_d    = ST_IDLE;
         y_d        = '0;
         y_valid_d  = 1'b0;
         scan_idx_d = '0;
         cnt_d      = '0;
      end else if (xfer) begin
         state_d   = ST_HOLD;
         y_d       = onehot(bus.sel);
         y_valid_d = 1'b1;
      end else if ((state_q == ST_HOLD) && (STICKY != 0)) begin
         state_d = ST_HOLD;
      end else begin
         state_d   = ST_IDLE;
         y_d       = '0;
         y_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         y_q        <= '0;
         y_valid_q  <= 1'b0;
         scan_idx_q <= '0;
         wrap_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         y_q        <= y_d;
         y_valid_q  <= y_valid_d;
         scan_idx_q <= scan_idx_d;
         wrap_q     <= wrap_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.sel_ready = sel_ready;
   assign bus.y         = (ACTIVE_LOW != 0) ? ~y_q : y_q;
   assign bus.y_valid   = y_valid_q;
   assign bus.scan_idx  = scan_idx_q;
   assign bus.wrap      = wrap_q;
endmodule
